// File: rtl/cic_comp_fir7_pkg.sv
// Shared definitions for the CIC droop-compensation FIR.
// Holds the datapath widths, the symmetric 7-tap coefficient set,
// the FSM state encoding and a guarded coefficient lookup helper.
package cic_comp_fir7_pkg;

   localparam int unsigned W_IN   = 10;
   localparam int unsigned W_COEF = 8;
   localparam int unsigned W_ACC  = 20;
   localparam int unsigned SHIFT  = 5;
   localparam int unsigned TAPS   = 7;
   localparam int unsigned W_PROD = W_IN + W_COEF;
   localparam int unsigned W_K    = 3;

   // Sum is 32, so a >>> 5 output scaling gives unity DC gain.
   localparam logic signed [W_COEF-1:0] COEF [TAPS] = '{
      -8'sd2, 8'sd5, -8'sd14, 8'sd54, -8'sd14, 8'sd5, -8'sd2
   };

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMac  = 2'd1;
   localparam logic [1:0] StOut  = 2'd2;

   // Tap index is 3 bits wide; index 7 has no coefficient and reads as zero.
   function automatic logic signed [W_COEF-1:0] coef_at(input logic [W_K-1:0] k);
      coef_at = (k < W_K'(TAPS)) ? COEF[k] : '0;
   endfunction

endpackage

// File: rtl/cic_comp_fir7_if.sv
// Sample interface of the compensation FIR.
//   x_in / x_valid   : input sample and its one-cycle strobe (from the CIC)
//   y_out / y_valid  : compensated sample and its one-cycle update pulse
//   busy             : filter is computing (not idle)
//   overrun          : sticky flag, a strobe arrived while busy and was dropped
// master drives samples in (upstream side); slave is the filter itself.
interface cic_comp_fir7_if;
   import cic_comp_fir7_pkg::*;

   logic signed [W_IN-1:0] x_in;
   logic                   x_valid;
   logic signed [W_IN-1:0] y_out;
   logic                   y_valid;
   logic                   busy;
   logic                   overrun;

   modport master (
      output x_in,
      output x_valid,
      input  y_out,
      input  y_valid,
      input  busy,
      input  overrun
   );

   modport slave (
      input  x_in,
      input  x_valid,
      output y_out,
      output y_valid,
      output busy,
      output overrun
   );

endinterface

// File: rtl/cic_comp_fir7_round_sat.sv
// Combinational round-half-up and saturate stage.
//   acc_i : WAcc-bit signed accumulator value
//   y_o   : (acc_i + 2^(Shift-1)) >>> Shift, clipped to the WOut-bit signed range
module cic_comp_fir7_round_sat
   import cic_comp_fir7_pkg::*;
#(
   parameter int unsigned WAcc  = W_ACC,
   parameter int unsigned WOut  = W_IN,
   parameter int unsigned Shift = SHIFT
) (
   input  logic signed [WAcc-1:0] acc_i,
   output logic signed [WOut-1:0] y_o
);

   // One guard bit so adding the rounding bias can never wrap.
   localparam int unsigned WExt = WAcc + 1;
   localparam logic signed [WExt-1:0] Bias = WExt'(2 ** (Shift - 1));
   localparam logic signed [WExt-1:0] Max  = WExt'(2 ** (WOut - 1) - 1);
   localparam logic signed [WExt-1:0] Min  = ~Max;

   logic signed [WExt-1:0] biased;
   logic signed [WExt-1:0] scaled;

   always_comb begin
      biased = {acc_i[WAcc-1], acc_i} + Bias;
      scaled = biased >>> Shift;
      if (scaled > Max) begin
         y_o = Max[WOut-1:0];
      end else if (scaled < Min) begin
         y_o = Min[WOut-1:0];
      end else begin
         y_o = scaled[WOut-1:0];
      end
   end

endmodule

// File: rtl/cic_comp_fir7.sv
// 7-tap serial-MAC FIR compensating the droop of a 3-stage, decimate-by-32 CIC.
// One multiplier is time-shared over 7 cycles per output sample.
//   clk    : fast clock shared with the CIC
//   reset  : asynchronous, active-low
//   bus    : slave side of cic_comp_fir7_if (x_in/x_valid in, y_out/y_valid/busy/overrun out)
// Timing: accept edge E0, MAC edges E1..E7 (taps 0..6), output edge E8.
module cic_comp_fir7
   import cic_comp_fir7_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   cic_comp_fir7_if.slave bus
);

   logic [1:0]              state_q, state_d;
   logic [W_K-1:0]          k_q, k_d;
   logic signed [W_ACC-1:0] acc_q, acc_d;
   logic signed [W_IN-1:0]  d_q [TAPS];
   logic signed [W_IN-1:0]  d_d [TAPS];
   logic signed [W_IN-1:0]  y_q, y_d;
   logic                    y_valid_q, y_valid_d;
   logic                    overrun_q, overrun_d;

   logic signed [W_IN-1:0]   d_sel;
   logic signed [W_COEF-1:0] c_sel;
   logic signed [W_PROD-1:0] prod;
   logic signed [W_IN-1:0]   y_rs;

   always_comb begin
      d_sel = (k_q < W_K'(TAPS)) ? d_q[k_q] : '0;
      c_sel = coef_at(k_q);
      prod  = W_PROD'(d_sel) * W_PROD'(c_sel);
   end

   cic_comp_fir7_round_sat #(
      .WAcc  (W_ACC),
      .WOut  (W_IN),
      .Shift (SHIFT)
   ) u_round_sat (
      .acc_i (acc_q),
      .y_o   (y_rs)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      acc_d     = acc_q;
      d_d       = d_q;
      y_d       = y_q;
      y_valid_d = 1'b0;
      overrun_d = overrun_q;
      case (state_q)
         StIdle: begin
            if (bus.x_valid) begin
               for (int i = TAPS - 1; i > 0; i--) begin
                  d_d[i] = d_q[i-1];
               end
               d_d[0]  = bus.x_in;
               acc_d   = '0;
               k_d     = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            acc_d = acc_q + W_ACC'(prod);
            if (k_q == W_K'(TAPS - 1)) begin
               k_d     = '0;
               state_d = StOut;
            end else begin
               k_d = k_q + W_K'(1);
            end
            // Strobes during a computation are dropped, never queued.
            if (bus.x_valid) begin
               overrun_d = 1'b1;
            end
         end
         StOut: begin
            y_d       = y_rs;
            y_valid_d = 1'b1;
            state_d   = StIdle;
            if (bus.x_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            k_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         k_q       <= '0;
         acc_q     <= '0;
         for (int i = 0; i < TAPS; i++) begin
            d_q[i] <= '0;
         end
         y_q       <= '0;
         y_valid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         acc_q     <= acc_d;
         d_q       <= d_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.y_out   = y_q;
   assign bus.y_valid = y_valid_q;
   assign bus.busy    = (state_q != StIdle);
   assign bus.overrun = overrun_q;

endmodule
